// File: rtl/add_ctrl_pkg.sv
// Shared defaults and state type for the slice-serial multiword adder.
package add_ctrl_pkg;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_NSLICE = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/full_adder.sv
// Combinational WIDTH-bit ripple adder slice.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] sum
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/multiword_add_ctrl.sv
// Multiword adder that reuses one WIDTH-bit slice adder over NSLICE cycles,
// with valid/ready handshakes on both the operand and the result side.
module multiword_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NSLICE = DEF_NSLICE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NSLICE-1:0] a,
    input  logic [WIDTH*NSLICE-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*NSLICE-1:0] sum,
    output logic                    cout
);
    localparam int W  = WIDTH * NSLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t          state;
    state_t          nxt;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            last;
    int              base;
    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic            slice_cout;

    assign base    = int'(cnt) * WIDTH;
    assign last    = (cnt == CW'(NSLICE - 1));
    assign slice_a = opa[base +: WIDTH];
    assign slice_b = opb[base +: WIDTH];

    full_adder #(.WIDTH(WIDTH)) u_fa (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .cout (slice_cout),
        .sum  (slice_sum)
    );

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = RUN;
            end
            RUN:     if (last) nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // sum is zeroed at accept so a stale result never mixes with new slices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[base +: WIDTH] <= slice_sum;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout      <= slice_cout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed and random checks of multiword_add_ctrl against a+b+cin.
module tb_multiword_add_ctrl;
    localparam int WIDTH  = 4;
    localparam int NSLICE = 4;
    localparam int W      = WIDTH * NSLICE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    int results  = 0;
    logic [W:0] expq[$];

    multiword_add_ctrl #(.WIDTH(WIDTH), .NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs,
                         input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called away from a clock edge; returns #1 after the IDLE-return edge.
    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input int stall);
        logic [W:0]   exp;
        logic [W-1:0] hs;
        logic         hc;
        int           n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {16'h0, in_ready}, 17'h1);
        a = ta;
        b = tb_;
        cin = tc;
        in_valid = 1'b1;
        expq.push_back({1'b0, ta} + {1'b0, tb_} + {16'h0, tc});
        accepts++;
        @(posedge clk);
        #1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        check("busy_ready", {16'h0, in_ready}, 17'h0);
        repeat (NSLICE - 1) @(posedge clk);
        #1;
        check("early_valid", {16'h0, out_valid}, 17'h0);
        @(posedge clk);
        #1;
        check("latency_valid", {16'h0, out_valid}, 17'h1);
        exp = expq.pop_front();
        results++;
        check("sum", {1'b0, sum}, {1'b0, exp[W-1:0]});
        check("cout", {16'h0, cout}, {16'h0, exp[W]});
        hs = sum;
        hc = cout;
        repeat (stall) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            check("hold_sum", {1'b0, sum}, {1'b0, hs});
            check("hold_cout", {16'h0, cout}, {16'h0, hc});
            check("hold_valid", {16'h0, out_valid}, 17'h1);
            check("hold_ready", {16'h0, in_ready}, 17'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_valid", {16'h0, out_valid}, 17'h0);
        check("drain_ready", {16'h0, in_ready}, 17'h1);
    endtask

    initial begin
        #12;
        check("rst_ready", {16'h0, in_ready}, 17'h1);
        check("rst_valid", {16'h0, out_valid}, 17'h0);
        check("rst_sum", {1'b0, sum}, 17'h0);
        check("rst_cout", {16'h0, cout}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(16'h1234, 16'h4321, 1'b0, 0);
        txn(16'h000F, 16'h0001, 1'b0, 0);
        txn(16'hFFFF, 16'hFFFF, 1'b1, 0);
        txn(16'h0F0F, 16'h7070, 1'b1, 5);

        a = 16'h9BBB;
        b = 16'hBBBB;
        cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("partial_sum", {1'b0, sum}, 17'h0006);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", {1'b0, sum}, 17'h0);
        check("arst_cout", {16'h0, cout}, 17'h0);
        check("arst_valid", {16'h0, out_valid}, 17'h0);
        check("arst_ready", {16'h0, in_ready}, 17'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("no_ghost_valid", {16'h0, out_valid}, 17'h0);
        end

        for (int i = 0; i < 20; i++) begin
            txn(W'($urandom), W'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
        end

        check("lost_or_dup", 17'(results), 17'(accepts));
        check("queue_empty", 17'(expq.size()), 17'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
